square_display: RTL and testbench

- Renders the `color`/`squares` control pair from the board's user logic as four coloured squares on a 640x480@60 Hz VGA output.
- Sits between the user logic and the VGA connector and runs on the 25 MHz pixel clock.
- Generates horizontal/vertical timing and paints a 2x2 grid of squares in the latched 3-bit colour.
- Control inputs are sampled once per frame, so no frame ever tears.

---
 rtl/square_display_pkg.sv | 37 +++
 rtl/vga_timing.sv | 98 +++++++++
 rtl/square_display.sv | 210 +++++++++++++++++++++
 tb/tb_square_display.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_display_pkg.sv
// Shared constants and types for the square_display block.
//
// Default 640x480@60 Hz timing (25 MHz pixel clock), derived totals and
// counter widths, and the quadrant index used by the square decoder.
// The quadrant encoding is {bottom, right}, so it indexes the `squares`
// mask directly: bit0 top-left, bit1 top-right, bit2 bottom-left,
// bit3 bottom-right.
package square_display_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SQ_SIZE  = 160;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_CNT_W = $clog2(DEF_H_TOTAL);
    localparam int DEF_V_CNT_W = $clog2(DEF_V_TOTAL);

    typedef enum logic [1:0] {
        QUAD_TL = 2'd0,
        QUAD_TR = 2'd1,
        QUAD_BL = 2'd2,
        QUAD_BR = 2'd3
    } quad_e;

    // Map "pixel is in the right half" / "pixel is in the bottom half" to a quadrant.
    function automatic quad_e quad_of(input logic right, input logic bottom);
        return quad_e'({bottom, right});
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator for square_display.
//
// Free-running pixel (h_cnt_r) and line (v_cnt_r) counters plus the
// combinational decode of the sync windows, the active-area flag and the
// frame boundary strobes. Decode outputs are unregistered; the parent
// applies the single output register stage.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous active-high reset (counters to 0,0)
//   h_cnt_r        pixel counter, 0..H_TOTAL-1
//   v_cnt_r        line counter, 0..V_TOTAL-1
//   hsync_s        active-low horizontal sync for the current count
//   vsync_s        active-low vertical sync for the current count
//   active_s       current count lies in the visible area
//   frame_start_s  current count is (0,0)
//   frame_end_s    current count is the last pixel of the frame
module vga_timing
    import square_display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int H_W     = $clog2(H_TOTAL),
    localparam int V_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] h_cnt_r,
    output logic [V_W-1:0] v_cnt_r,
    output logic           hsync_s,
    output logic           vsync_s,
    output logic           active_s,
    output logic           frame_start_s,
    output logic           frame_end_s
);

    localparam logic [H_W-1:0] H_ONE_C    = H_W'(1);
    localparam logic [V_W-1:0] V_ONE_C    = V_W'(1);
    localparam logic [H_W-1:0] H_LAST_C   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST_C   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_C    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_C    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_FIRST_C = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_LAST_C  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] VS_FIRST_C = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_LAST_C  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pixel and line counters; the line advances when the pixel count wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= '0;
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= '0;
            end else begin
                v_cnt_r <= v_cnt_r + V_ONE_C;
            end
        end else begin
            h_cnt_r <= h_cnt_r + H_ONE_C;
        end
    end

    // Sync windows, visible area and frame boundary decode from the counters.
    always_comb begin
        hsync_s       = 1'b1;
        vsync_s       = 1'b1;
        active_s      = 1'b0;
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;

        if ((h_cnt_r >= HS_FIRST_C) && (h_cnt_r <= HS_LAST_C)) begin
            hsync_s = 1'b0;
        end else begin
            hsync_s = 1'b1;
        end

        if ((v_cnt_r >= VS_FIRST_C) && (v_cnt_r <= VS_LAST_C)) begin
            vsync_s = 1'b0;
        end else begin
            vsync_s = 1'b1;
        end

        active_s      = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        frame_start_s = (h_cnt_r == '0) && (v_cnt_r == '0);
        frame_end_s   = (h_cnt_r == H_LAST_C) && (v_cnt_r == V_LAST_C);
    end

endmodule

// File: rtl/square_display.sv
// Four-square VGA renderer.
//
// Shows the user logic's `color`/`squares` pair as a 2x2 grid of squares,
// each centred in its screen quadrant, on a 640x480@60 Hz raster. Inputs
// are latched on the last pixel of each frame so a frame never tears.
// Every output is registered: outputs in cycle t describe the raster
// position the counters held in cycle t-1.
//
// Build option: define SQUARE_OUTLINE_EN to draw unlit squares as a
// 1-pixel outline in the latched colour (lit squares stay filled).
//
// Ports:
//   clk          25 MHz pixel clock (only clock)
//   rst          synchronous active-high reset
//   color        {r,g,b} colour of lit squares
//   squares      lit-square mask (bit0 TL, bit1 TR, bit2 BL, bit3 BR)
//   hsync        active-low horizontal sync
//   vsync        active-low vertical sync
//   red/green/blue  pixel colour, 0 outside the visible area
//   frame_start  one-cycle pulse with output pixel (0,0)
module square_display
    import square_display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SQ_SIZE  = DEF_SQ_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] color,
    input  logic [3:0] squares,
    output logic       hsync,
    output logic       vsync,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    // Quadrant size and the square's span in quadrant-local coordinates.
    localparam int QW    = H_ACTIVE / 2;
    localparam int QH    = V_ACTIVE / 2;
    localparam int X_OFF = (QW - SQ_SIZE) / 2;
    localparam int Y_OFF = (QH - SQ_SIZE) / 2;

    localparam logic [H_W-1:0] QW_C   = H_W'(QW);
    localparam logic [V_W-1:0] QH_C   = V_W'(QH);
    localparam logic [H_W-1:0] X_LO_C = H_W'(X_OFF);
    localparam logic [H_W-1:0] X_HI_C = H_W'(X_OFF + SQ_SIZE - 1);
    localparam logic [V_W-1:0] Y_LO_C = V_W'(Y_OFF);
    localparam logic [V_W-1:0] Y_HI_C = V_W'(Y_OFF + SQ_SIZE - 1);

    logic [H_W-1:0] h_cnt_r;
    logic [V_W-1:0] v_cnt_r;
    logic           hsync_s;
    logic           vsync_s;
    logic           active_s;
    logic           frame_start_s;
    logic           frame_end_s;

    logic [2:0]     color_q_r;
    logic [3:0]     squares_q_r;

    logic [H_W-1:0] loc_x_s;
    logic [V_W-1:0] loc_y_s;
    quad_e          quad_s;
    logic           in_sq_s;
    logic           lit_s;
    logic [2:0]     rgb_s;

    logic           hsync_r;
    logic           vsync_r;
    logic [2:0]     rgb_r;
    logic           frame_start_r;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .h_cnt_r       (h_cnt_r),
        .v_cnt_r       (v_cnt_r),
        .hsync_s       (hsync_s),
        .vsync_s       (vsync_s),
        .active_s      (active_s),
        .frame_start_s (frame_start_s),
        .frame_end_s   (frame_end_s)
    );

    // Frame latch: inputs captured on the last pixel so the next frame sees them whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q_r   <= 3'b001;
            squares_q_r <= 4'b0000;
        end else if (frame_end_s) begin
            color_q_r   <= color;
            squares_q_r <= squares;
        end else begin
            color_q_r   <= color_q_r;
            squares_q_r <= squares_q_r;
        end
    end

    // Quadrant selection and quadrant-local coordinates of the current pixel.
    always_comb begin
        loc_x_s = h_cnt_r;
        loc_y_s = v_cnt_r;
        quad_s  = quad_of(h_cnt_r >= QW_C, v_cnt_r >= QH_C);

        if (h_cnt_r >= QW_C) begin
            loc_x_s = h_cnt_r - QW_C;
        end else begin
            loc_x_s = h_cnt_r;
        end

        if (v_cnt_r >= QH_C) begin
            loc_y_s = v_cnt_r - QH_C;
        end else begin
            loc_y_s = v_cnt_r;
        end
    end

    // Square hit test and the latched enable bit of the quadrant in view.
    always_comb begin
        in_sq_s = (loc_x_s >= X_LO_C) && (loc_x_s <= X_HI_C) &&
                  (loc_y_s >= Y_LO_C) && (loc_y_s <= Y_HI_C);
        lit_s   = 1'b0;
        case (quad_s)
            QUAD_TL: lit_s = squares_q_r[0];
            QUAD_TR: lit_s = squares_q_r[1];
            QUAD_BL: lit_s = squares_q_r[2];
            QUAD_BR: lit_s = squares_q_r[3];
            default: lit_s = 1'b0;
        endcase
    end

`ifdef SQUARE_OUTLINE_EN
    logic on_edge_s;

    // Border ring of the square, used to outline unlit squares.
    always_comb begin
        on_edge_s = in_sq_s &&
                    ((loc_x_s == X_LO_C) || (loc_x_s == X_HI_C) ||
                     (loc_y_s == Y_LO_C) || (loc_y_s == Y_HI_C));
    end

    // Pixel colour: filled lit squares, outlined unlit squares, black elsewhere.
    always_comb begin
        rgb_s = 3'b000;
        if (active_s && in_sq_s && lit_s) begin
            rgb_s = color_q_r;
        end else if (active_s && on_edge_s) begin
            rgb_s = color_q_r;
        end else begin
            rgb_s = 3'b000;
        end
    end
`else
    // Pixel colour: filled lit squares, black elsewhere.
    always_comb begin
        rgb_s = 3'b000;
        if (active_s && in_sq_s && lit_s) begin
            rgb_s = color_q_r;
        end else begin
            rgb_s = 3'b000;
        end
    end
`endif

    // Single output register stage keeping sync, colour and frame pulse aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            rgb_r         <= 3'b000;
            frame_start_r <= 1'b0;
        end else begin
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            rgb_r         <= rgb_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign red         = rgb_r[2];
    assign green       = rgb_r[1];
    assign blue        = rgb_r[0];
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_square_display.sv
// Directed self-checking bench for square_display.
//
// The DUT runs a scaled raster (80x55 total, 64x48 visible, 16-pixel
// squares) so several whole frames fit in a short run. Geometry for this
// configuration: quadrant 32x24, square offset x=8 y=4, so squares span
// x 8..23 / 40..55 and y 4..19 / 28..43; hsync low h 68..75, vsync low
// v 50..51; one frame = 4400 cycles.
//
// ph/pv track the raster position the DUT outputs currently describe.
module tb_square_display;

    localparam int HA = 64, HFP = 4, HS = 8, HB = 4;
    localparam int VA = 48, VFP = 2, VS = 2, VB = 3;
    localparam int SQ = 16;
    localparam int HT = 80, VT = 55;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] color = 3'b000;
    logic [3:0] squares = 4'b0000;
    logic       hsync, vsync, red, green, blue, frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    int ph = -1;
    int pv = 0;

    square_display #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
        .SQ_SIZE  (SQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .color       (color),
        .squares     (squares),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Advance one clock and update the position the outputs now reflect.
    task automatic step();
        @(posedge clk);
        #1;
        if (ph < 0) begin
            ph = 0;
            pv = 0;
        end else if (ph == HT - 1) begin
            ph = 0;
            pv = (pv == VT - 1) ? 0 : pv + 1;
        end else begin
            ph = ph + 1;
        end
    endtask

    // Step forward (at least once) until the outputs reflect (x,y); bounded.
    task automatic goto(input int x, input int y);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(ph == x && pv == y) && n < 2 * FRAME);
        n_cmp++;
        if (!(ph == x && pv == y)) begin
            n_bad++;
            $display("FAIL goto: reached (%0d,%0d) required (%0d,%0d)", ph, pv, x, y);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({hsync, vsync, red, green, blue, frame_start} !== 6'b110000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 110000",
                     {hsync, vsync, red, green, blue, frame_start});
        end
        rst = 1'b0;
        ph  = -1;
        step();
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL first_frame_start: got %b required 1", frame_start);
        end
    endtask

    // Two frames of sync/frame_start checking plus blanking, black first frame.
    task automatic test_timing();
        int hs_err = 0, vs_err = 0, fs_err = 0, blank_err = 0, lit0 = 0;
        int hs_low = 0, vs_low = 0, fs_cnt = 0, fs_first = -1, fs_gap = -1;
        logic exp_hs, exp_vs, exp_fs;
        for (int i = 0; i < 2 * FRAME; i++) begin
            exp_hs = !(ph >= HA + HFP && ph <= HA + HFP + HS - 1);
            exp_vs = !(pv >= VA + VFP && pv <= VA + VFP + VS - 1);
            exp_fs = (ph == 0 && pv == 0);
            if (hsync !== exp_hs) hs_err++;
            if (vsync !== exp_vs) vs_err++;
            if (frame_start !== exp_fs) fs_err++;
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) begin
                if (fs_cnt == 0) fs_first = i;
                else if (fs_cnt == 1) fs_gap = i - fs_first;
                fs_cnt++;
            end
            if ((ph >= HA || pv >= VA) && {red, green, blue} !== 3'b000) blank_err++;
            if (i < FRAME && {red, green, blue} !== 3'b000) lit0++;
            step();
        end
        n_cmp++;
        if (hs_err !== 0) begin n_bad++; $display("FAIL hsync_window: got %0d bad cycles required 0", hs_err); end
        n_cmp++;
        if (vs_err !== 0) begin n_bad++; $display("FAIL vsync_window: got %0d bad cycles required 0", vs_err); end
        n_cmp++;
        if (fs_err !== 0) begin n_bad++; $display("FAIL frame_start_pos: got %0d bad cycles required 0", fs_err); end
        n_cmp++;
        if (hs_low !== 2 * VT * HS) begin n_bad++; $display("FAIL hsync_low_count: got %0d required %0d", hs_low, 2 * VT * HS); end
        n_cmp++;
        if (vs_low !== 2 * VS * HT) begin n_bad++; $display("FAIL vsync_low_count: got %0d required %0d", vs_low, 2 * VS * HT); end
        n_cmp++;
        if (fs_cnt !== 2) begin n_bad++; $display("FAIL frame_start_count: got %0d required 2", fs_cnt); end
        n_cmp++;
        if (fs_gap !== FRAME) begin n_bad++; $display("FAIL frame_start_gap: got %0d required %0d", fs_gap, FRAME); end
        n_cmp++;
        if (blank_err !== 0) begin n_bad++; $display("FAIL blank_frames01: got %0d lit blank pixels required 0", blank_err); end
        n_cmp++;
        if (lit0 !== 0) begin n_bad++; $display("FAIL frame0_black: got %0d lit pixels required 0", lit0); end
    endtask

    // Only top-left lit in red; edges and other quadrants black.
    task automatic test_single_square();
        int         xs[9] = '{8, 7, 8, 24, 40, 23, 23, 8, 40};
        int         ys[9] = '{3, 4, 4, 4, 4, 19, 20, 28, 28};
        logic [2:0] ex[9] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000,
                              3'b100, 3'b000, 3'b000, 3'b000};
        for (int k = 0; k < 9; k++) begin
            goto(xs[k], ys[k]);
            n_cmp++;
            if ({red, green, blue} !== ex[k]) begin
                n_bad++;
                $display("FAIL single_square(%0d,%0d): got %b required %b",
                         xs[k], ys[k], {red, green, blue}, ex[k]);
            end
        end
    endtask

    // Mask change mid-frame appears only from the following frame.
    task automatic test_frame_latch();
        int         xs[7] = '{8, 40, 8, 40, 55, 56, 40};
        int         ys[7] = '{10, 30, 4, 28, 43, 43, 44};
        logic [2:0] ex[7] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
        goto(0, 10);
        squares = 4'b1000;
        for (int k = 0; k < 7; k++) begin
            goto(xs[k], ys[k]);
            n_cmp++;
            if ({red, green, blue} !== ex[k]) begin
                n_bad++;
                $display("FAIL frame_latch(%0d,%0d): got %b required %b",
                         xs[k], ys[k], {red, green, blue}, ex[k]);
            end
        end
    endtask

    // All squares white for a frame: 4*16*16 lit pixels, none outside the active area.
    task automatic test_blanking();
        int lit = 0, blank_err = 0;
        squares = 4'b1111;
        color   = 3'b111;
        goto(0, 0);
        for (int i = 0; i < FRAME; i++) begin
            if ({red, green, blue} === 3'b111) lit++;
            if ((ph >= HA || pv >= VA) && {red, green, blue} !== 3'b000) blank_err++;
            step();
        end
        n_cmp++;
        if (lit !== 4 * SQ * SQ) begin n_bad++; $display("FAIL lit_count: got %0d required %0d", lit, 4 * SQ * SQ); end
        n_cmp++;
        if (blank_err !== 0) begin n_bad++; $display("FAIL blanking: got %0d lit blank pixels required 0", blank_err); end
    endtask

    task automatic test_mid_reset();
        goto(16, 10);
        n_cmp++;
        if ({red, green, blue} !== 3'b111) begin
            n_bad++;
            $display("FAIL pre_reset_pixel: got %b required 111", {red, green, blue});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({hsync, vsync, red, green, blue, frame_start} !== 6'b110000) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b required 110000",
                     {hsync, vsync, red, green, blue, frame_start});
        end
        ph = -1;
        step();
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_frame_start: got %b required 1", frame_start);
        end
        goto(8, 4);
        n_cmp++;
        if ({red, green, blue} !== 3'b000) begin
            n_bad++;
            $display("FAIL post_reset_black: got %b required 000", {red, green, blue});
        end
        goto(8, 4);
        n_cmp++;
        if ({red, green, blue} !== 3'b111) begin
            n_bad++;
            $display("FAIL post_reset_relatch: got %b required 111", {red, green, blue});
        end
    endtask

    // Unlit squares: outlined in the outline build, black otherwise.
    task automatic test_outline();
        int         xs[3] = '{8, 9, 23};
        int         ys[3] = '{4, 5, 10};
`ifdef SQUARE_OUTLINE_EN
        logic [2:0] ex[3] = '{3'b010, 3'b000, 3'b010};
`else
        logic [2:0] ex[3] = '{3'b000, 3'b000, 3'b000};
`endif
        squares = 4'b0000;
        color   = 3'b010;
        for (int k = 0; k < 3; k++) begin
            goto(xs[k], ys[k]);
            n_cmp++;
            if ({red, green, blue} !== ex[k]) begin
                n_bad++;
                $display("FAIL outline(%0d,%0d): got %b required %b",
                         xs[k], ys[k], {red, green, blue}, ex[k]);
            end
        end
    endtask

    initial begin
        color   = 3'b100;
        squares = 4'b0001;
        test_reset();
        test_timing();
        test_single_square();
        test_frame_latch();
        test_blanking();
        test_mid_reset();
        test_outline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
